lsu: RTL and testbench

Load/store unit forming the MEM stage of the 5-stage RV32I pipeline, between the EX/MEM pipeline register and the MEM/WB writeback path. It replaces the flat byte-array data memory with a request/acknowledge bus to an external data memory. It supports byte, half and word accesses with byte strobes and sign/zero extension, stalls the pipeline while a bus access is outstanding, and reports misaligned and timed-out accesses as exceptions.

---
 rtl/lsu_pkg.sv | 26 ++
 rtl/lsu_lane.sv | 55 +++++
 rtl/lsu.sv | 186 ++++++++++++++++++
 tb/tb_lsu.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the MEM-stage load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } lsu_state_e;

  // Access size taken from funct3[1:0]; codes 3/6/7 fall into the word case
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam logic [3:0] CAUSE_LD_MIS = 4'd4;
  localparam logic [3:0] CAUSE_LD_FLT = 4'd5;
  localparam logic [3:0] CAUSE_ST_MIS = 4'd6;
  localparam logic [3:0] CAUSE_ST_FLT = 4'd7;

  function automatic int cnt_width(input int timeout);
    int w;
    w = $clog2(timeout);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte-lane steering for stores and lane extract plus sign/zero extension for loads.
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_data,
  output logic [3:0]  st_strb,
  output logic [31:0] st_wdata,
  input  logic [1:0]  ld_size,
  input  logic        ld_uns,
  input  logic [1:0]  ld_off,
  input  logic [31:0] ld_data,
  output logic [31:0] ld_ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    st_strb  = 4'hF;
    st_wdata = st_data;
    case (st_size)
      SZ_B: begin
        st_strb  = 4'b0001 << st_off;
        st_wdata = {4{st_data[7:0]}};
      end
      SZ_H: begin
        st_strb  = st_off[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{st_data[15:0]}};
      end
      default: begin
        st_strb  = 4'hF;
        st_wdata = st_data;
      end
    endcase
  end

  // Half-word lane uses only off[1]; word ignores the offset entirely
  always_comb begin
    case (ld_off)
      2'd0:    byte_sel = ld_data[7:0];
      2'd1:    byte_sel = ld_data[15:8];
      2'd2:    byte_sel = ld_data[23:16];
      default: byte_sel = ld_data[31:24];
    endcase
    half_sel = ld_off[1] ? ld_data[31:16] : ld_data[15:0];
    case (ld_size)
      SZ_B:    ld_ext = ld_uns ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      SZ_H:    ld_ext = ld_uns ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: ld_ext = ld_data;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// MEM-stage load/store unit: req/ack data bus, stalls while busy, misaligned/timeout exceptions.
// Misalignment traps are enabled by defining LSU_MISALIGN_TRAP_EN.
module lsu
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        exc_valid,
  output logic [3:0]  exc_cause,
  output logic [31:0] exc_addr
);

  localparam int CW = cnt_width(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  lsu_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic          accept, bus_ack, bus_to, done, in_bus, misalign;

  logic          we_p1;
  logic [2:0]    f3_p1;
  logic [31:0]   addr_p1;
  logic [4:0]    rd_p1;
  logic [3:0]    wstrb_p1;
  logic [31:0]   wdata_p1;

  logic          wb_valid_p2, exc_valid_p2;
  logic [4:0]    wb_rd_p2;
  logic [31:0]   wb_data_p2, exc_addr_p2;
  logic [3:0]    exc_cause_p2;

  logic [3:0]    st_strb;
  logic [31:0]   st_wdata, ld_ext;

  lsu_lane u_lane (
    .st_size  (req_funct3[1:0]),
    .st_off   (req_addr[1:0]),
    .st_data  (req_wdata),
    .st_strb  (st_strb),
    .st_wdata (st_wdata),
    .ld_size  (f3_p1[1:0]),
    .ld_uns   (f3_p1[2]),
    .ld_off   (addr_p1[1:0]),
    .ld_data  (mem_rdata),
    .ld_ext   (ld_ext)
  );

`ifdef LSU_MISALIGN_TRAP_EN
  always_comb begin
    case (req_funct3[1:0])
      SZ_B:    misalign = 1'b0;
      SZ_H:    misalign = req_addr[0];
      default: misalign = |req_addr[1:0];
    endcase
  end
`else
  assign misalign = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    bus_ack = 1'b0;
    bus_to  = 1'b0;
    done    = 1'b0;
    in_bus  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          accept  = 1'b1;
          state_d = misalign ? ST_RESP : ST_BUS;
        end
      end
      ST_BUS: begin
        in_bus = 1'b1;
        if (mem_ack) begin
          bus_ack = 1'b1;
          state_d = ST_RESP;
        end else if (cnt_q == CNT_LAST) begin
          bus_to  = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Wait counter: value k means k unacknowledged BUS cycles already elapsed
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                                     cnt_q <= '0;
    else if (state_q == ST_BUS && state_d == ST_BUS) cnt_q <= cnt_q + 1'b1;
    else                                             cnt_q <= '0;
  end

  // Request capture stage
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      we_p1    <= 1'b0;
      f3_p1    <= 3'd0;
      addr_p1  <= 32'h0;
      rd_p1    <= 5'd0;
      wstrb_p1 <= 4'h0;
      wdata_p1 <= 32'h0;
    end else if (accept) begin
      we_p1    <= req_we;
      f3_p1    <= req_funct3;
      addr_p1  <= req_addr;
      rd_p1    <= req_rd;
      wstrb_p1 <= req_we ? st_strb : 4'h0;
      wdata_p1 <= st_wdata;
    end
  end

  // Response stage: pulses are high only during RESP; data holds between events
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wb_valid_p2  <= 1'b0;
      wb_rd_p2     <= 5'd0;
      wb_data_p2   <= 32'h0;
      exc_valid_p2 <= 1'b0;
      exc_cause_p2 <= 4'd0;
      exc_addr_p2  <= 32'h0;
    end else begin
      wb_valid_p2  <= 1'b0;
      exc_valid_p2 <= 1'b0;
      if (bus_ack && !we_p1) begin
        wb_valid_p2 <= 1'b1;
        wb_rd_p2    <= rd_p1;
        wb_data_p2  <= ld_ext;
      end
      if (accept && misalign) begin
        exc_valid_p2 <= 1'b1;
        exc_cause_p2 <= req_we ? CAUSE_ST_MIS : CAUSE_LD_MIS;
        exc_addr_p2  <= req_addr;
      end
      if (bus_to) begin
        exc_valid_p2 <= 1'b1;
        exc_cause_p2 <= we_p1 ? CAUSE_ST_FLT : CAUSE_LD_FLT;
        exc_addr_p2  <= addr_p1;
      end
    end
  end

  // Reset gates stall directly so it falls with the asynchronous reset
  assign stall     = reset & req_valid & ~done;
  assign mem_req   = in_bus;
  assign mem_we    = we_p1 & in_bus;
  assign mem_addr  = {addr_p1[31:2], 2'b00};
  assign mem_wstrb = wstrb_p1 & {4{in_bus}};
  assign mem_wdata = wdata_p1;
  assign wb_valid  = wb_valid_p2;
  assign wb_rd     = wb_rd_p2;
  assign wb_data   = wb_data_p2;
  assign exc_valid = exc_valid_p2;
  assign exc_cause = exc_cause_p2;
  assign exc_addr  = exc_addr_p2;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: zero-wait accesses, lane steering, misalignment, timeout, mid-access reset.
module tb_lsu;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        stall, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        exc_valid;
  logic [3:0]  exc_cause;
  logic [31:0] exc_addr;

  int n_cmp = 0;
  int n_err = 0;
  int hi;

  lsu #(.TIMEOUT(16)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_rd     (req_rd),
    .stall      (stall),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wstrb  (mem_wstrb),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .exc_valid  (exc_valid),
    .exc_cause  (exc_cause),
    .exc_addr   (exc_addr)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [4:0] rd);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    req_rd     = rd;
  endtask

  // Zero-wait access: accept cycle, one BUS cycle with ack, then RESP
  task automatic zw_access(input string tag, input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdata, input logic [31:0] exp_addr,
                           input logic [3:0] exp_strb, input logic [31:0] exp_wdata,
                           input logic [31:0] exp_data);
    drive(we, f3, addr, wdata, 5'd7);
    mem_ack   = 1'b1;
    mem_rdata = rdata;
    @(negedge clock);
    chk({tag, ".acc_stall"}, 32'(stall), 32'd1);
    chk({tag, ".acc_req"}, 32'(mem_req), 32'd0);
    @(negedge clock);
    chk({tag, ".bus_req"}, 32'(mem_req), 32'd1);
    chk({tag, ".bus_we"}, 32'(mem_we), 32'(we));
    chk({tag, ".bus_addr"}, mem_addr, exp_addr);
    chk({tag, ".bus_strb"}, 32'(mem_wstrb), 32'(exp_strb));
    if (we) chk({tag, ".bus_wdata"}, mem_wdata, exp_wdata);
    chk({tag, ".bus_stall"}, 32'(stall), 32'd1);
    @(negedge clock);
    chk({tag, ".resp_stall"}, 32'(stall), 32'd0);
    chk({tag, ".resp_req"}, 32'(mem_req), 32'd0);
    chk({tag, ".resp_wbv"}, 32'(wb_valid), 32'(!we));
    chk({tag, ".resp_exc"}, 32'(exc_valid), 32'd0);
    if (!we) begin
      chk({tag, ".wb_data"}, wb_data, exp_data);
      chk({tag, ".wb_rd"}, 32'(wb_rd), 32'd7);
    end
    @(posedge clock); #1;
    req_valid = 1'b0;
    mem_ack   = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'h0; req_wdata = 32'h0; req_rd = 5'd0;
    mem_ack = 1'b0; mem_rdata = 32'h0;

    #3;
    chk("rst.mem_req", 32'(mem_req), 32'd0);
    chk("rst.stall", 32'(stall), 32'd0);
    chk("rst.wb_valid", 32'(wb_valid), 32'd0);
    chk("rst.exc_valid", 32'(exc_valid), 32'd0);
    chk("rst.wb_data", wb_data, 32'h0);
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;

    zw_access("sw",  1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 32'h0, 32'h10, 4'hF, 32'hDEADBEEF, 32'h0);
    zw_access("lb",  1'b0, 3'd0, 32'h13, 32'h0, 32'h80FF_0000, 32'h10, 4'h0, 32'h0, 32'hFFFFFF80);
    zw_access("lbu", 1'b0, 3'd4, 32'h13, 32'h0, 32'h80FF_0000, 32'h10, 4'h0, 32'h0, 32'h00000080);
    zw_access("lhu", 1'b0, 3'd5, 32'h12, 32'h0, 32'h80FF_0000, 32'h10, 4'h0, 32'h0, 32'h000080FF);
    zw_access("sb",  1'b1, 3'd0, 32'h05, 32'h000000AB, 32'h0, 32'h04, 4'b0010, 32'hABABABAB, 32'h0);
    zw_access("lh",  1'b0, 3'd1, 32'h20, 32'h0, 32'h1234_9ABC, 32'h20, 4'h0, 32'h0, 32'hFFFF9ABC);
    zw_access("sh",  1'b1, 3'd1, 32'h22, 32'h0000_5AA5, 32'h0, 32'h20, 4'b1100, 32'h5AA55AA5, 32'h0);

`ifdef LSU_MISALIGN_TRAP_EN
    drive(1'b0, 3'd2, 32'h06, 32'h0, 5'd9);
    mem_ack = 1'b1;
    @(negedge clock);
    chk("mis.acc_req", 32'(mem_req), 32'd0);
    @(negedge clock);
    chk("mis.exc_valid", 32'(exc_valid), 32'd1);
    chk("mis.exc_cause", 32'(exc_cause), 32'd4);
    chk("mis.exc_addr", exc_addr, 32'h06);
    chk("mis.mem_req", 32'(mem_req), 32'd0);
    chk("mis.wb_valid", 32'(wb_valid), 32'd0);
    chk("mis.wb_hold", wb_data, 32'hFFFF9ABC);
    chk("mis.stall", 32'(stall), 32'd0);
    @(posedge clock); #1;
    req_valid = 1'b0; mem_ack = 1'b0;
`else
    zw_access("lw_mis", 1'b0, 3'd2, 32'h06, 32'h0, 32'h1234_5678, 32'h04, 4'h0, 32'h0, 32'h12345678);
`endif

    // Store that is never acknowledged
    drive(1'b1, 3'd2, 32'h40, 32'h1111_2222, 5'd0);
    mem_ack = 1'b0;
    @(posedge clock);
    hi = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (mem_req) hi++;
      else break;
    end
    chk("to.req_cycles", 32'(hi), 32'd16);
    chk("to.exc_valid", 32'(exc_valid), 32'd1);
    chk("to.exc_cause", 32'(exc_cause), 32'd7);
    chk("to.exc_addr", exc_addr, 32'h40);
    @(posedge clock); #1;
    req_valid = 1'b0;
    @(negedge clock);
    chk("to.exc_pulse", 32'(exc_valid), 32'd0);

    // Reset while waiting in BUS
    @(posedge clock); #1;
    drive(1'b0, 3'd2, 32'h30, 32'h0, 5'd3);
    mem_ack = 1'b0;
    @(posedge clock);
    @(posedge clock); @(posedge clock); @(posedge clock); #1;
    chk("rbus.req_before", 32'(mem_req), 32'd1);
    reset = 1'b0;
    #1;
    chk("rbus.mem_req", 32'(mem_req), 32'd0);
    chk("rbus.stall", 32'(stall), 32'd0);
    chk("rbus.wb_valid", 32'(wb_valid), 32'd0);
    chk("rbus.wb_data", wb_data, 32'h0);
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    chk("rbus.no_exc", 32'(exc_valid), 32'd0);
    req_valid = 1'b0;
    @(posedge clock); #1;
    zw_access("lw_after", 1'b0, 3'd2, 32'h24, 32'h0, 32'hCAFE_F00D, 32'h24, 4'h0, 32'h0, 32'hCAFEF00D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
